// File: rtl/i_cache.sv
// Direct-mapped, read-only instruction cache sitting between instruction fetch
// and a combinational-read instruction ROM. Hits are answered in the same
// cycle. A miss fills the whole line from the ROM, one word per clock.
module i_cache #(
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned INDEX_WIDTH  = 5,
    parameter int unsigned OFFSET_WIDTH = 3
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_rd,
    output logic [DATA_WIDTH-1:0] o_inst,
    output logic                  o_busy,
    output logic                  o_hit,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic [DATA_WIDTH-1:0] i_mem_data
);

    localparam int unsigned TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int unsigned LINES     = 1 << INDEX_WIDTH;
    localparam int unsigned WORDS     = 1 << OFFSET_WIDTH;
    localparam logic [OFFSET_WIDTH-1:0] LAST_WORD = '1;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t                  state_q;
    logic [OFFSET_WIDTH-1:0] cnt_q;
    logic [TAG_WIDTH-1:0]    miss_tag_q;
    logic [INDEX_WIDTH-1:0]  miss_idx_q;
    logic [LINES-1:0]        valid_q;
    logic [TAG_WIDTH-1:0]    tag_q  [LINES];
    logic [DATA_WIDTH-1:0]   data_q [LINES][WORDS];

    logic [TAG_WIDTH-1:0]    req_tag;
    logic [INDEX_WIDTH-1:0]  req_idx;
    logic [OFFSET_WIDTH-1:0] req_off;
    logic                    lookup_hit;
    logic                    hit;
    logic                    miss;

    assign req_tag = i_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign req_idx = i_addr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign req_off = i_addr[OFFSET_WIDTH-1:0];

    assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign hit        = !i_reset && (state_q == IDLE) && i_rd && lookup_hit;
    assign miss       = !i_reset && (state_q == IDLE) && i_rd && !lookup_hit;

    // Same-cycle response; everything is forced low while reset is held
    always_comb begin
        o_hit      = hit;
        o_busy     = 1'b0;
        o_inst     = '0;
        o_mem_addr = '0;
        if (hit) begin
            o_inst = data_q[req_idx][req_off];
        end
        if (!i_reset) begin
            if (state_q == FILL) begin
                o_busy     = 1'b1;
                o_mem_addr = {miss_tag_q, miss_idx_q, cnt_q};
            end else if (miss) begin
                o_busy = 1'b1;
            end
        end
    end

    // Control FSM: miss detection, fill sequencing and line valid bits
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss) begin
                        // Invalidate up front so a half-written line can never hit
                        miss_tag_q       <= req_tag;
                        miss_idx_q       <= req_idx;
                        valid_q[req_idx] <= 1'b0;
                        cnt_q            <= '0;
                        state_q          <= FILL;
                    end
                end
                FILL: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        valid_q[miss_idx_q] <= 1'b1;
                        state_q             <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag and data storage; not reset, validity is tracked by valid_q alone
    always_ff @(posedge i_clock) begin
        if (!i_reset && (state_q == FILL)) begin
            data_q[miss_idx_q][cnt_q] <= i_mem_data;
            if (cnt_q == LAST_WORD) begin
                tag_q[miss_idx_q] <= miss_tag_q;
            end
        end
    end

endmodule

// File: tb/tb_i_cache.sv
// Scoreboard bench for i_cache: directed scenarios followed by random traffic,
// checked against a line-level behavioural model of the cache.
module tb_i_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] addr;
    logic        rd;
    logic [31:0] inst;
    logic        busy;
    logic        hit;
    logic [11:0] mem_addr;
    logic [31:0] mem_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        hit;
        logic        busy;
        logic [31:0] inst;
        logic [11:0] maddr;
    } exp_t;

    exp_t exp_q[$];

    // Model state: per-line residency plus remaining fill cycles
    bit        m_valid [32];
    bit [3:0]  m_tag   [32];
    int        fill_left = 0;
    logic [11:0] fill_base = '0;

    always #5 clk = ~clk;

    // ROM: each word holds its own address
    assign mem_data = {20'h0, mem_addr};

    i_cache #(
        .ADDR_WIDTH  (12),
        .DATA_WIDTH  (32),
        .INDEX_WIDTH (5),
        .OFFSET_WIDTH(3)
    ) dut (
        .i_clock   (clk),
        .i_reset   (rst),
        .i_addr    (addr),
        .i_rd      (rd),
        .o_inst    (inst),
        .o_busy    (busy),
        .o_hit     (hit),
        .o_mem_addr(mem_addr),
        .i_mem_data(mem_data)
    );

    // Drive one cycle of stimulus, queue its expected response, advance model
    task automatic do_cycle(input logic r, input logic d, input logic [11:0] a);
        exp_t e;
        logic [4:0] idx;
        @(posedge clk);
        #1;
        rst  = r;
        rd   = d;
        addr = a;
        e.hit = 1'b0; e.busy = 1'b0; e.inst = '0; e.maddr = '0;
        if (r) begin
            for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
            fill_left = 0;
        end else if (fill_left > 0) begin
            e.busy  = 1'b1;
            e.maddr = fill_base + 12'(8 - fill_left);
            fill_left = fill_left - 1;
            if (fill_left == 0) begin
                m_valid[fill_base[7:3]] = 1'b1;
                m_tag[fill_base[7:3]]   = fill_base[11:8];
            end
        end else if (d) begin
            idx = a[7:3];
            if (m_valid[idx] && m_tag[idx] == a[11:8]) begin
                e.hit  = 1'b1;
                e.inst = {20'h0, a};
            end else begin
                e.busy       = 1'b1;
                m_valid[idx] = 1'b0;
                fill_left    = 8;
                fill_base    = {a[11:3], 3'b000};
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic read_n(input logic [11:0] a, input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b1, a);
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 12'h000);
    endtask

    // Monitor: compare DUT outputs against the queued expectation mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (hit !== e.hit) begin
                errors++;
                $display("FAIL o_hit addr=%h got %b want %b t=%0t", addr, hit, e.hit, $time);
            end
            checks++;
            if (busy !== e.busy) begin
                errors++;
                $display("FAIL o_busy addr=%h got %b want %b t=%0t", addr, busy, e.busy, $time);
            end
            checks++;
            if (inst !== e.inst) begin
                errors++;
                $display("FAIL o_inst addr=%h got %h want %h t=%0t", addr, inst, e.inst, $time);
            end
            checks++;
            if (mem_addr !== e.maddr) begin
                errors++;
                $display("FAIL o_mem_addr got %h want %h t=%0t", mem_addr, e.maddr, $time);
            end
        end
    end

    initial begin
        int guard;
        rst  = 1'b1;
        rd   = 1'b0;
        addr = '0;
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
        end

        // Reset, cold miss on 0x010, then hits within the line
        do_cycle(1'b1, 1'b0, 12'h000);
        do_cycle(1'b1, 1'b1, 12'h010);
        read_n(12'h010, 9);
        read_n(12'h010, 1);
        read_n(12'h012, 1);
        read_n(12'h017, 1);
        read_n(12'h011, 1);

        // Conflict eviction on index 2
        read_n(12'hF11, 9);
        read_n(12'hF11, 1);
        read_n(12'h011, 9);
        read_n(12'h011, 1);
        read_n(12'hF11, 9);
        idle_n(1);

        // Single-cycle request pulse still completes the fill
        read_n(12'h123, 1);
        idle_n(9);
        read_n(12'h123, 1);

        // Reset during the 4th fill cycle aborts the fill
        read_n(12'h200, 1);
        idle_n(3);
        do_cycle(1'b1, 1'b0, 12'h000);
        idle_n(1);
        read_n(12'h200, 9);
        read_n(12'h205, 1);

        // Two distinct indices both resident
        read_n(12'h010, 9);
        read_n(12'h020, 9);
        read_n(12'h010, 1);
        read_n(12'h020, 1);
        read_n(12'h027, 1);

        // Random traffic over a small set of lines to force hits and evictions
        for (int i = 0; i < 3000; i++) begin
            logic        r;
            logic        d;
            logic [11:0] a;
            r = ($urandom_range(0, 199) < 3);
            d = ($urandom_range(0, 99) < 70);
            a = {4'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
            do_cycle(r, d, a);
        end
        idle_n(2);

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
